stream_fifo: RTL and testbench

- Synchronous single-clock FIFO with first-word-fall-through (FWFT) and valid/ready handshakes on both sides.
- Buffers blocks between producer and consumer stages, e.g. the AES output controller, which stores 128-bit data plus a last flag.
- Reports full, almost-full and empty status to upstream flow control.

---
 rtl/stream_fifo_pkg.sv | 15 +
 rtl/stream_fifo_ram.sv | 26 ++
 rtl/stream_fifo.sv | 133 +++++++++++++
 tb/tb_stream_fifo.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/stream_fifo_pkg.sv
// Shared handshake-operation encoding for the stream FIFO.
package stream_fifo_pkg;

  typedef enum logic [1:0] {
    SF_OP_IDLE  = 2'd0,
    SF_OP_WRITE = 2'd1,
    SF_OP_READ  = 2'd2,
    SF_OP_BOTH  = 2'd3
  } sf_op_e;

  function automatic sf_op_e sf_decode(input logic wr_en, input logic rd_en);
    return sf_op_e'({rd_en, wr_en});
  endfunction

endpackage

// File: rtl/stream_fifo_ram.sv
// DEPTH x DATA_WIDTH storage: synchronous write, asynchronous read, no reset.
module stream_fifo_ram #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];

  // storage write port
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/stream_fifo.sv
// First-word-fall-through stream FIFO with valid/ready on both sides.
// Optional macro STREAM_FIFO_COUNT_EN exposes the occupancy as fifo_count.
module stream_fifo
  import stream_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  fifo_write_tvalid,
  output logic                  fifo_write_tready,
  input  logic [DATA_WIDTH-1:0] fifo_wdata,
  output logic                  fifo_read_tvalid,
  input  logic                  fifo_read_tready,
  output logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  fifo_almost_full,
  output logic                  fifo_full,
  output logic                  fifo_empty
`ifdef STREAM_FIFO_COUNT_EN
  ,
  output logic [ADDR_WIDTH:0]   fifo_count
`endif
);

  localparam logic [ADDR_WIDTH-1:0] LP_PTR_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] LP_PTR_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] LP_LAST_PTR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   LP_CNT_ZERO = {(ADDR_WIDTH+1){1'b0}};
  localparam logic [ADDR_WIDTH:0]   LP_CNT_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0]   LP_DEPTH    = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   LP_AFULL    = (ADDR_WIDTH+1)'(DEPTH - 1);

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_empty;
  logic                  r_full;
  logic                  r_almost_full;

  logic [ADDR_WIDTH-1:0] w_wr_ptr_nxt;
  logic [ADDR_WIDTH-1:0] w_rd_ptr_nxt;
  logic [ADDR_WIDTH:0]   w_count_nxt;
  logic                  w_wr_en;
  logic                  w_rd_en;
  sf_op_e                w_op;

  // Wrap explicitly so non-power-of-two depths never index past DEPTH-1.
  function automatic logic [ADDR_WIDTH-1:0] f_ptr_inc(input logic [ADDR_WIDTH-1:0] ptr);
    if (ptr == LP_LAST_PTR) begin
      return LP_PTR_ZERO;
    end else begin
      return ptr + LP_PTR_ONE;
    end
  endfunction

  assign fifo_write_tready = !r_full;
  assign fifo_read_tvalid  = !r_empty;
  assign fifo_full         = r_full;
  assign fifo_empty        = r_empty;
  assign fifo_almost_full  = r_almost_full;

  assign w_wr_en = fifo_write_tvalid && !r_full;
  assign w_rd_en = fifo_read_tready && !r_empty;
  assign w_op    = sf_decode(w_wr_en, w_rd_en);

  // next pointer and occupancy from the accepted handshakes
  always_comb begin
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    w_count_nxt  = r_count;
    case (w_op)
      SF_OP_WRITE: begin
        w_wr_ptr_nxt = f_ptr_inc(r_wr_ptr);
        w_count_nxt  = r_count + LP_CNT_ONE;
      end
      SF_OP_READ: begin
        w_rd_ptr_nxt = f_ptr_inc(r_rd_ptr);
        w_count_nxt  = r_count - LP_CNT_ONE;
      end
      SF_OP_BOTH: begin
        w_wr_ptr_nxt = f_ptr_inc(r_wr_ptr);
        w_rd_ptr_nxt = f_ptr_inc(r_rd_ptr);
      end
      SF_OP_IDLE: begin
        w_count_nxt = r_count;
      end
      default: begin
        w_count_nxt = r_count;
      end
    endcase
  end

  // Flags are registered from the next count so handshakes come straight off flops.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr      <= LP_PTR_ZERO;
      r_rd_ptr      <= LP_PTR_ZERO;
      r_count       <= LP_CNT_ZERO;
      r_empty       <= 1'b1;
      r_full        <= 1'b0;
      r_almost_full <= 1'b0;
    end else begin
      r_wr_ptr      <= w_wr_ptr_nxt;
      r_rd_ptr      <= w_rd_ptr_nxt;
      r_count       <= w_count_nxt;
      r_empty       <= (w_count_nxt == LP_CNT_ZERO);
      r_full        <= (w_count_nxt == LP_DEPTH);
      r_almost_full <= (w_count_nxt >= LP_AFULL);
    end
  end

  stream_fifo_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk       (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (fifo_wdata),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (fifo_rdata)
  );

`ifdef STREAM_FIFO_COUNT_EN
  assign fifo_count = r_count;
`else
  // occupancy stays internal and only drives the status flags
`endif

endmodule

// File: tb/tb_stream_fifo.sv
// Scoreboard bench: a 16-deep and a 12-deep stream_fifo driven in lockstep.
module tb_stream_fifo;

  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          resetn;
  logic          wv;
  logic          rr;
  logic [DW-1:0] wd;

  logic          a_wready, a_rvalid, a_afull, a_full, a_empty;
  logic [DW-1:0] a_rdata;
  logic          b_wready, b_rvalid, b_afull, b_full, b_empty;
  logic [DW-1:0] b_rdata;
`ifdef STREAM_FIFO_COUNT_EN
  logic [4:0]    a_count;
  logic [4:0]    b_count;
`endif

  int            n_tests = 0;
  int            n_fail  = 0;
  int            ma = 0;
  int            mb = 0;
  logic [DW-1:0] qa[$];
  logic [DW-1:0] qb[$];

  always #5 clk = ~clk;

  stream_fifo #(.ADDR_WIDTH(4), .DATA_WIDTH(DW), .DEPTH(16)) u_dut_a (
    .clk               (clk),
    .resetn            (resetn),
    .fifo_write_tvalid (wv),
    .fifo_write_tready (a_wready),
    .fifo_wdata        (wd),
    .fifo_read_tvalid  (a_rvalid),
    .fifo_read_tready  (rr),
    .fifo_rdata        (a_rdata),
    .fifo_almost_full  (a_afull),
    .fifo_full         (a_full),
    .fifo_empty        (a_empty)
`ifdef STREAM_FIFO_COUNT_EN
    , .fifo_count      (a_count)
`endif
  );

  stream_fifo #(.ADDR_WIDTH(4), .DATA_WIDTH(DW), .DEPTH(12)) u_dut_b (
    .clk               (clk),
    .resetn            (resetn),
    .fifo_write_tvalid (wv),
    .fifo_write_tready (b_wready),
    .fifo_wdata        (wd),
    .fifo_read_tvalid  (b_rvalid),
    .fifo_read_tready  (rr),
    .fifo_rdata        (b_rdata),
    .fifo_almost_full  (b_afull),
    .fifo_full         (b_full),
    .fifo_empty        (b_empty)
`ifdef STREAM_FIFO_COUNT_EN
    , .fifo_count      (b_count)
`endif
  );

  task automatic chkw(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_flags();
    chk1("a_empty",   a_empty,  ma == 0);
    chk1("a_full",    a_full,   ma == 16);
    chk1("a_afull",   a_afull,  ma >= 15);
    chk1("a_rvalid",  a_rvalid, ma != 0);
    chk1("a_wready",  a_wready, ma != 16);
    chk1("b_empty",   b_empty,  mb == 0);
    chk1("b_full",    b_full,   mb == 12);
    chk1("b_afull",   b_afull,  mb >= 11);
    chk1("b_rvalid",  b_rvalid, mb != 0);
    chk1("b_wready",  b_wready, mb != 12);
`ifdef STREAM_FIFO_COUNT_EN
    chkw("a_count", DW'(a_count), DW'(ma));
    chkw("b_count", DW'(b_count), DW'(mb));
`endif
  endtask

  // One clock: drive, predict acceptance, push expected data, check flags.
  task automatic step(input logic w, input logic [DW-1:0] d, input logic r);
    logic aw, ar, bw, br;
    @(posedge clk);
    #1;
    wv = w;
    wd = d;
    rr = r;
    aw = w && (ma != 16);
    ar = r && (ma != 0);
    bw = w && (mb != 12);
    br = r && (mb != 0);
    if (aw) qa.push_back(d);
    if (bw) qb.push_back(d);
    @(negedge clk);
    check_flags();
    ma = ma + int'(aw) - int'(ar);
    mb = mb + int'(bw) - int'(br);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    wv = 1'b0;
    rr = 1'b0;
    wd = '0;
    #2;
    resetn = 1'b0;
    #1;
    chk1("async_a_empty",  a_empty,  1'b1);
    chk1("async_a_rvalid", a_rvalid, 1'b0);
    chk1("async_a_wready", a_wready, 1'b1);
    chk1("async_b_empty",  b_empty,  1'b1);
    qa.delete();
    qb.delete();
    ma = 0;
    mb = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  // monitor: every read handshake must present the oldest expected word
  always @(negedge clk) begin
    if (resetn === 1'b1 && a_rvalid === 1'b1 && rr === 1'b1) begin
      if (qa.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL a_underrun: got %0h expected no read at %0t", a_rdata, $time);
      end else begin
        chkw("a_rdata", a_rdata, qa.pop_front());
      end
    end
    if (resetn === 1'b1 && b_rvalid === 1'b1 && rr === 1'b1) begin
      if (qb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL b_underrun: got %0h expected no read at %0t", b_rdata, $time);
      end else begin
        chkw("b_rdata", b_rdata, qb.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    wv = 1'b0;
    rr = 1'b0;
    wd = '0;
    resetn = 1'b1;
    #1;
    resetn = 1'b0;
    #1;
    chk1("rst_a_empty",  a_empty,  1'b1);
    chk1("rst_a_full",   a_full,   1'b0);
    chk1("rst_a_afull",  a_afull,  1'b0);
    chk1("rst_a_rvalid", a_rvalid, 1'b0);
    chk1("rst_a_wready", a_wready, 1'b1);
    chk1("rst_b_empty",  b_empty,  1'b1);
    @(negedge clk);
    resetn = 1'b1;

    // single word, fall-through visible one cycle after the write
    step(1'b1, DW'(128'hA5), 1'b0);
    step(1'b0, '0, 1'b0);
    chkw("fwft_a_rdata", a_rdata, DW'(128'hA5));
    chkw("fwft_b_rdata", b_rdata, DW'(128'hA5));
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);

    // fill past full; the overflow offers must be dropped
    for (int i = 0; i < 17; i++) step(1'b1, DW'(i), 1'b0);
    step(1'b0, '0, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);

    // full with simultaneous read: only the read happens, write lands next cycle
    for (int i = 0; i < 16; i++) step(1'b1, DW'(100 + i), 1'b0);
    step(1'b1, DW'(200), 1'b1);
    step(1'b1, DW'(201), 1'b0);
    step(1'b0, '0, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);

    // steady-state streaming at occupancy 8, wrapping the pointers
    for (int i = 0; i < 8; i++) step(1'b1, DW'(300 + i), 1'b0);
    for (int i = 0; i < 40; i++) step(1'b1, DW'(400 + i), 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);

    // occupancy after three writes and one read
    for (int i = 0; i < 3; i++) step(1'b1, DW'(500 + i), 1'b0);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);

    // reset with five words stored discards them
    for (int i = 0; i < 5; i++) step(1'b1, DW'(600 + i), 1'b0);
    step(1'b0, '0, 1'b0);
    do_reset();
    step(1'b0, '0, 1'b0);
    step(1'b1, DW'(128'hBEEF), 1'b0);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);

    chkw("a_drained", DW'(qa.size()), DW'(0));
    chkw("b_drained", DW'(qb.size()), DW'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
